mult_pipe_approx: RTL and testbench

MULT_PIPE_APPROX -- requirements
Module: mult_pipe_approx

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_partial_products.sv | 44 ++++
 rtl/mult_pipe_approx.sv | 144 ++++++++++++++
 tb/tb_mult_pipe_approx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the approximate split multiplier.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: mode encoding and the default operand, split and counter widths.
package mult_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int DEF_W     = 32;
  localparam int DEF_L     = 18;
  localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/mult_partial_products.sv
// Splits both operands at bit L and forms the four partial products.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller registers the outputs when it can.
//
// Ports:
//   i_a, i_b : W-bit unsigned operands
//   o_p1     : AH*BH (2H bits)
//   o_p2     : AH*BL (H+L bits)
//   o_p3     : AL*BH (H+L bits)
//   o_p4     : AL*BL (2L bits)
module mult_partial_products
  import mult_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int L = DEF_L
) (
  input  logic [W-1:0]       i_a,
  input  logic [W-1:0]       i_b,
  output logic [2*(W-L)-1:0] o_p1,
  output logic [W-1:0]       o_p2,
  output logic [W-1:0]       o_p3,
  output logic [2*L-1:0]     o_p4
);

  localparam int H = W - L;

  logic [H-1:0] w_ah;
  logic [H-1:0] w_bh;
  logic [L-1:0] w_al;
  logic [L-1:0] w_bl;

  assign w_ah = i_a[W-1:L];
  assign w_al = i_a[L-1:0];
  assign w_bh = i_b[W-1:L];
  assign w_bl = i_b[L-1:0];

  // Operands are zero-extended to the product width so every multiply is
  // evaluated at full precision without relying on context sizing.
  assign o_p1 = {{H{1'b0}}, w_ah} * {{H{1'b0}}, w_bh};
  assign o_p2 = {{L{1'b0}}, w_ah} * {{H{1'b0}}, w_bl};
  assign o_p3 = {{H{1'b0}}, w_al} * {{L{1'b0}}, w_bh};
  assign o_p4 = {{L{1'b0}}, w_al} * {{L{1'b0}}, w_bl};

endmodule

// File: rtl/mult_pipe_approx.sv
// Two-stage unsigned multiplier with an exact mode and an approximate mode that drops AL*BL.
// Latency: result registered two edges after accept (accept edge loads S1, next edge loads S2).
// Backpressure: valid/ready; holds up to two results, in_ready falls combinationally when both stages are full and out_ready=0.
//
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake; A, B, mode sampled on transfer
//   out_valid/out_ready  : product handshake; P, out_mode held while stalled
//   op_count             : completed output transfers, wrapping
module mult_pipe_approx
  import mult_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int L     = DEF_L,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   P,
  output logic             out_mode,
  output logic [CNT_W-1:0] op_count
);

  localparam int H = W - L;

  // Partial products from the operand inputs
  logic [2*H-1:0] w_p1;
  logic [W-1:0]   w_p2;
  logic [W-1:0]   w_p3;
  logic [2*L-1:0] w_p4;

  // Stage 1 state
  logic           r_s1_vld;
  logic [2*H-1:0] r_p1;
  logic [W-1:0]   r_p2;
  logic [W-1:0]   r_p3;
  logic [2*L-1:0] r_p4;
  logic           r_s1_mode;

  // Stage 2 state
  logic           r_s2_vld;
  logic [2*W-1:0] r_p;
  logic           r_out_mode;
  logic [CNT_W-1:0] r_cnt;

  // Handshake / accumulation wires
  logic           w_s2_free;
  logic           w_in_xfer;
  logic           w_out_xfer;
  logic [2*L-1:0] w_p4_eff;
  logic [W:0]     w_mid;
  logic [2*W-1:0] w_t1;
  logic [2*W-1:0] w_t2;
  logic [2*W-1:0] w_t3;
  logic [2*W-1:0] w_sum;

  mult_partial_products #(
    .W (W),
    .L (L)
  ) u_pp (
    .i_a  (A),
    .i_b  (B),
    .o_p1 (w_p1),
    .o_p2 (w_p2),
    .o_p3 (w_p3),
    .o_p4 (w_p4)
  );

  // S2 can take new content when empty or when its result leaves this cycle.
  // S1 can take new content when empty or when it moves into S2; this keeps
  // full throughput with no bubble while out_ready stays high.
  assign w_s2_free  = !r_s2_vld || out_ready;
  assign in_ready   = !r_s1_vld || w_s2_free;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_s2_vld && out_ready;

  // Accumulation: the middle term gets one extra bit so P2+P3 cannot wrap;
  // every term is widened to 2W before the final add.
  assign w_p4_eff = (r_s1_mode == MODE_APPROX) ? '0 : r_p4;
  assign w_mid    = {1'b0, r_p2} + {1'b0, r_p3};
  assign w_t1     = {r_p1, {(2*L){1'b0}}};
  assign w_t2     = {{(W-1){1'b0}}, w_mid} << L;
  assign w_t3     = {{(2*H){1'b0}}, w_p4_eff};
  assign w_sum    = w_t1 + w_t2 + w_t3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_p1      <= '0;
      r_p2      <= '0;
      r_p3      <= '0;
      r_p4      <= '0;
      r_s1_mode <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_vld <= in_valid;
      end
      // Operand registers only move on an actual transfer so stalled or idle
      // inputs never disturb held data.
      if (w_in_xfer) begin
        r_p1      <= w_p1;
        r_p2      <= w_p2;
        r_p3      <= w_p3;
        r_p4      <= w_p4;
        r_s1_mode <= mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld   <= 1'b0;
      r_p        <= '0;
      r_out_mode <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_p        <= w_sum;
        r_out_mode <= r_s1_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_out_xfer) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_vld;
  assign P         = r_p;
  assign out_mode  = r_out_mode;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_mult_pipe_approx.sv
// Directed and table-driven checks for mult_pipe_approx (W=32, L=18), plus a
// CNT_W=4 instance sharing the same stimulus for counter wrap.
module tb_mult_pipe_approx;

  localparam int W = 32;
  localparam int L = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] P;
  logic          out_mode;
  logic [31:0]   op_count;

  logic          in_ready_4;
  logic          out_valid_4;
  logic [2*W-1:0] P_4;
  logic          out_mode_4;
  logic [3:0]    op_count_4;

  always #5 clk = ~clk;

  mult_pipe_approx #(.W(W), .L(L), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .P(P), .out_mode(out_mode), .op_count(op_count)
  );

  mult_pipe_approx #(.W(W), .L(L), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
    .A(A), .B(B), .mode(mode), .out_valid(out_valid_4), .out_ready(out_ready),
    .P(P_4), .out_mode(out_mode_4), .op_count(op_count_4)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        m;
    logic [63:0] exp_p;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  int n_cmp = 0;
  int n_bad = 0;
  int n_emit = 0;
  logic [64:0] exp_q [$];

  // Reference: exact product, minus AL*BL in approximate mode.
  function automatic logic [63:0] ref_p(input logic [31:0] a, input logic [31:0] b,
                                        input logic m);
    logic [63:0] full;
    logic [63:0] lo;
    full = {32'd0, a} * {32'd0, b};
    lo   = {46'd0, a[17:0]} * {46'd0, b[17:0]};
    return m ? (full - lo) : full;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven. Records transfers
  // that will happen on the coming rising edge, then returns at the next
  // falling edge.
  task automatic step(output logic acc);
    logic        emit;
    logic [64:0] e;
    #1;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    if (emit) begin
      n_emit++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got P=0x%h, expected no output", P);
      end else begin
        e = exp_q.pop_front();
        chk("out_p", P, e[63:0]);
        chk("out_mode", {63'd0, out_mode}, {63'd0, e[64]});
        chk("dut4_p", P_4, e[63:0]);
        chk("dut4_mode", {63'd0, out_mode_4}, {63'd0, e[64]});
      end
    end
    if (acc) exp_q.push_back({mode, ref_p(A, B, mode)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    n_emit = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic [31:0] pa_a [3];
    logic [31:0] pa_b [3];
    logic        pa_m [3];
    int idx;
    int stalls;

    vt[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
    vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFEE_00080000};
    vt[2] = '{32'h00000000, 32'h00000000, 1'b0, 64'h0};
    vt[3] = '{32'h00000003, 32'h00000005, 1'b0, 64'd15};
    vt[4] = '{32'h00000003, 32'h00000005, 1'b1, 64'd0};
    vt[5] = '{32'h00040000, 32'h00040000, 1'b1, 64'h00000010_00000000};
    vt[6] = '{32'h0003FFFF, 32'h00040000, 1'b1, 64'h0000000F_FFFC0000};
    vt[7] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000_FFFFFFFF};
    vt[8] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'h00000000_FFFC0000};
    vt[9] = '{32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000};

    A = '0; B = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_valid4", {63'd0, out_valid_4}, 64'd0);
    chk("rst_p", P, 64'd0);
    chk("rst_out_mode", {63'd0, out_mode}, 64'd0);
    chk("rst_op_count", {32'd0, op_count}, 64'd0);
    chk("rst_op_count4", {60'd0, op_count_4}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_in_ready4", {63'd0, in_ready_4}, 64'd1);
    @(negedge clk);

    // Table: one vector at a time, checking the two-edge latency.
    for (int i = 0; i < NV; i++) begin
      A = vt[i].a; B = vt[i].b; mode = vt[i].m; in_valid = 1'b1;
      step(acc);
      chk("vec_accept", {63'd0, acc}, 64'd1);
      in_valid = 1'b0;
      A = $urandom; B = $urandom; mode = ~vt[i].m;
      chk("vec_lat_early", {63'd0, out_valid}, 64'd0);
      step(acc);
      chk("vec_valid", {63'd0, out_valid}, 64'd1);
      chk("vec_p", P, vt[i].exp_p);
      chk("vec_mode", {63'd0, out_mode}, {63'd0, vt[i].m});
      if (i == 1) chk("vec_approx_low", {46'd0, P[17:0]}, 64'd0);
      step(acc);
    end
    chk("table_op_count", {32'd0, op_count}, 64'd10);

    // Back-to-back random stream with mixed modes.
    do_reset();
    stalls = 0;
    for (int i = 0; i < 1000; i++) begin
      A = $urandom; B = $urandom; mode = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      step(acc);
      if (!acc) stalls++;
    end
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_rate", 64'(n_emit), 64'd998);
    in_valid = 1'b0;
    step(acc);
    step(acc);
    chk("stream_emits", 64'(n_emit), 64'd1000);
    chk("stream_op_count", {32'd0, op_count}, 64'd1000);
    chk("stream_op_count4", {60'd0, op_count_4}, 64'd8);
    chk("stream_q_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: out_ready low for 5 cycles while offering 3 pairs.
    do_reset();
    pa_a[0] = 32'h12345678; pa_b[0] = 32'h9ABCDEF0; pa_m[0] = 1'b0;
    pa_a[1] = 32'hDEADBEEF; pa_b[1] = 32'hCAFEF00D; pa_m[1] = 1'b1;
    pa_a[2] = 32'h0001FFFF; pa_b[2] = 32'hFFFE0001; pa_m[2] = 1'b0;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) begin
        A = pa_a[idx]; B = pa_b[idx]; mode = pa_m[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step(acc);
      if (acc) idx++;
      if (c == 3) chk("bp_p_mid", P, ref_p(pa_a[0], pa_b[0], pa_m[0]));
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_p_end", P, ref_p(pa_a[0], pa_b[0], pa_m[0]));
    chk("bp_mode_end", {63'd0, out_mode}, {63'd0, pa_m[0]});
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (idx < 3) begin
        A = pa_a[idx]; B = pa_b[idx]; mode = pa_m[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step(acc);
      if (acc) idx++;
      if (idx == 3 && exp_q.size() == 0) break;
    end
    chk("bp_release_emits", 64'(n_emit), 64'd3);
    chk("bp_release_accepted", 64'(idx), 64'd3);
    chk("bp_release_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream with two results held.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      A = $urandom; B = $urandom; mode = 1'(i); in_valid = 1'b1;
      step(acc);
    end
    in_valid = 1'b0;
    chk("rmid_out_valid", {63'd0, out_valid}, 64'd1);
    chk("rmid_in_ready", {63'd0, in_ready}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_async_valid", {63'd0, out_valid}, 64'd0);
    chk("rmid_p", P, 64'd0);
    chk("rmid_op_count", {32'd0, op_count}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    n_emit = 0;
    repeat (5) step(acc);
    chk("rmid_no_stale", 64'(n_emit), 64'd0);

    // 17 transfers: the 4-bit counter wraps to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      A = $urandom; B = $urandom; mode = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      step(acc);
    end
    in_valid = 1'b0;
    repeat (3) step(acc);
    chk("wrap_op_count", {32'd0, op_count}, 64'd17);
    chk("wrap_op_count4", {60'd0, op_count_4}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
